// File: rtl/queue_ctrl_if.sv
// Bundles the request side and the RAM port of the queue controller.
// slave is the controller's view; master is the view of whoever drives requests and models the RAM.
interface queue_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          enq;
    logic          deq;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;
    logic          udf;
    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_spo;

    modport slave (
        input  enq, deq, din, ram_spo,
        output dout, dout_vld, full, empty, count, ovf, udf, ram_we, ram_a, ram_d
    );

    modport master (
        output enq, deq, din, ram_spo,
        input  dout, dout_vld, full, empty, count, ovf, udf, ram_we, ram_a, ram_d
    );
endinterface

// File: rtl/queue_ctrl.sv
// FIFO controller in front of a single-port RAM (async read, sync write).
// Turns enq/deq rising edges into one-cycle RAM accesses and registers the dequeued byte.
module queue_ctrl #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    queue_ctrl_if.slave bus
);
    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic          pend_q, pend_d;
    logic [DW-1:0] pend_data_q, pend_data_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_vld_q, dout_vld_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          enq_q, enq_d;
    logic          deq_q, deq_d;

    logic          enq_e, deq_e;
    logic          full, empty;
    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d;

    assign enq_e = bus.enq & ~enq_q;
    assign deq_e = bus.deq & ~deq_q;
    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);

    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        dout_d      = dout_q;
        dout_vld_d  = 1'b0;
        ovf_d       = 1'b0;
        udf_d       = 1'b0;
        enq_d       = bus.enq;
        deq_d       = bus.deq;
        ram_we      = 1'b0;
        ram_a       = rp_q;
        ram_d       = bus.din;

        if (pend_q) begin
            // Deferred half of a simultaneous enq/deq; the dequeue already freed a slot.
            ram_we  = 1'b1;
            ram_a   = wp_q;
            ram_d   = pend_data_q;
            wp_d    = wp_q + AW'(1);
            count_d = count_q + (AW+1)'(1);
            pend_d  = 1'b0;
        end else if (deq_e && !empty) begin
            dout_d     = bus.ram_spo;
            dout_vld_d = 1'b1;
            rp_d       = rp_q + AW'(1);
            count_d    = count_q - (AW+1)'(1);
            if (enq_e) begin
                pend_d      = 1'b1;
                pend_data_d = bus.din;
            end
        end else if (enq_e && !full) begin
            ram_we  = 1'b1;
            ram_a   = wp_q;
            wp_d    = wp_q + AW'(1);
            count_d = count_q + (AW+1)'(1);
            udf_d   = deq_e;
        end else begin
            ovf_d = enq_e & full;
            udf_d = deq_e & empty;
        end

        // A reset cycle must never commit a write, even with a pending enqueue.
        if (rst) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            enq_q       <= 1'b1;
            deq_q       <= 1'b1;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            enq_q       <= enq_d;
            deq_q       <= deq_d;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.ovf      = ovf_q;
    assign bus.udf      = udf_q;
    assign bus.ram_we   = ram_we;
    assign bus.ram_a    = ram_a;
    assign bus.ram_d    = ram_d;
endmodule

// File: tb/tb_queue_ctrl.sv
// Directed bench for queue_ctrl with a 16x8 RAM model and a FIFO scoreboard.
// Enqueued bytes are pushed when driven and popped when dout_vld is expected.
module tb_queue_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    queue_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    queue_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [DW-1:0] mem [0:(2**AW)-1];
    int            write_cnt = 0;
    assign bus.ram_spo = mem[bus.ram_a];
    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_a] <= bus.ram_d;
            write_cnt      <= write_cnt + 1;
        end
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    int            mcount   = 0;
    logic [DW-1:0] last_dout = '0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"}, 32'(bus.count), 32'(mcount));
        check({tag, ".empty"}, 32'(bus.empty), 32'(mcount == 0));
        check({tag, ".full"},  32'(bus.full),  32'(mcount == 16));
    endtask

    task automatic do_enq(input logic [DW-1:0] d);
        logic exp_ovf;
        exp_ovf = (mcount == 16);
        if (!exp_ovf) begin
            exp_q.push_back(d);
            mcount++;
        end
        bus.enq = 1'b1;
        bus.din = d;
        cyc();
        $display("enq %02h count=%0d ovf=%0b", d, bus.count, bus.ovf);
        check("enq.ovf", 32'(bus.ovf), 32'(exp_ovf));
        check_status("enq");
        bus.enq = 1'b0;
        cyc();
        check("enq.ovf_pulse", 32'(bus.ovf), 32'(0));
        cyc();
    endtask

    task automatic do_deq();
        logic [DW-1:0] exp_d;
        logic          exp_vld;
        exp_vld = (mcount != 0);
        if (exp_vld) begin
            exp_d = exp_q.pop_front();
            mcount--;
            last_dout = exp_d;
        end else begin
            exp_d = last_dout;
        end
        bus.deq = 1'b1;
        cyc();
        $display("deq dout=%02h vld=%0b udf=%0b count=%0d", bus.dout, bus.dout_vld, bus.udf, bus.count);
        check("deq.vld", 32'(bus.dout_vld), 32'(exp_vld));
        check("deq.dout", 32'(bus.dout), 32'(exp_d));
        check("deq.udf", 32'(bus.udf), 32'(!exp_vld));
        check_status("deq");
        bus.deq = 1'b0;
        cyc();
        check("deq.vld_pulse", 32'(bus.dout_vld), 32'(0));
        cyc();
    endtask

    // Simultaneous enq/deq edges; models deferred commit when non-empty.
    task automatic do_both(input logic [DW-1:0] d);
        logic [DW-1:0] exp_d;
        bus.enq = 1'b1;
        bus.deq = 1'b1;
        bus.din = d;
        if (mcount != 0) begin
            exp_d = exp_q.pop_front();
            last_dout = exp_d;
            exp_q.push_back(d);
            cyc();
            $display("both %02h dout=%02h vld=%0b count=%0d", d, bus.dout, bus.dout_vld, bus.count);
            check("both.vld", 32'(bus.dout_vld), 32'(1));
            check("both.dout", 32'(bus.dout), 32'(exp_d));
            check("both.count_mid", 32'(bus.count), 32'(mcount - 1));
            check("both.ovf", 32'(bus.ovf), 32'(0));
            bus.enq = 1'b0;
            bus.deq = 1'b0;
            cyc();
            check("both.ovf2", 32'(bus.ovf), 32'(0));
            check_status("both");
        end else begin
            exp_q.push_back(d);
            mcount = 1;
            cyc();
            $display("both %02h udf=%0b count=%0d", d, bus.udf, bus.count);
            check("both.udf", 32'(bus.udf), 32'(1));
            check("both.vld_empty", 32'(bus.dout_vld), 32'(0));
            check_status("both_empty");
            bus.enq = 1'b0;
            bus.deq = 1'b0;
            cyc();
        end
        cyc();
    endtask

    initial begin
        int wc;
        bus.enq = 1'b0;
        bus.deq = 1'b0;
        bus.din = '0;
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        $display("reset count=%0d empty=%0b dout=%02h", bus.count, bus.empty, bus.dout);
        check_status("reset");
        check("reset.dout", 32'(bus.dout), 32'(0));
        check("reset.vld", 32'(bus.dout_vld), 32'(0));
        check("reset.ovf", 32'(bus.ovf), 32'(0));
        check("reset.udf", 32'(bus.udf), 32'(0));

        // T1
        do_enq(8'h11);
        do_enq(8'h22);
        do_enq(8'h33);
        repeat (3) do_deq();

        // T2: fill, overflow, drain (pointers wrap)
        for (int i = 0; i < 16; i++) do_enq(8'(i));
        do_enq(8'hEE);
        for (int i = 0; i < 16; i++) do_deq();

        // T3
        do_deq();

        // T4: full queue, simultaneous enq/deq
        for (int i = 0; i < 16; i++) do_enq(8'(8'h40 + i));
        do_both(8'hAA);
        for (int i = 0; i < 16; i++) do_deq();

        // T5: empty queue, simultaneous enq/deq
        do_both(8'h5C);
        do_deq();

        // T6: reset while a deferred enqueue is pending
        do_enq(8'h77);
        bus.enq = 1'b1;
        bus.deq = 1'b1;
        bus.din = 8'h99;
        cyc();
        check("t6.dout", 32'(bus.dout), 32'h77);
        wc = write_cnt;
        bus.deq = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        mcount = 0;
        last_dout = '0;
        repeat (2) cyc();
        $display("t6 count=%0d empty=%0b writes=%0d", bus.count, bus.empty, write_cnt - wc);
        check("t6.writes", 32'(write_cnt), 32'(wc));
        check_status("t6");
        check("t6.ovf", 32'(bus.ovf), 32'(0));
        check("t6.udf", 32'(bus.udf), 32'(0));
        bus.enq = 1'b0;
        cyc();
        do_deq();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
